// File: rtl/spram_arbiter_if.sv
// Request/grant/read-return bus between two requesters (A, B) and the
// single-port RAM arbiter.
interface spram_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    logic             req_a;
    logic             req_b;
    logic             we_a;
    logic             we_b;
    logic [DEPTH-1:0] addr_a;
    logic [DEPTH-1:0] addr_b;
    logic [WIDTH-1:0] wdata_a;
    logic [WIDTH-1:0] wdata_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             rvalid_a;
    logic             rvalid_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
    );

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
    );
endinterface

// File: rtl/spram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port RAM with 2-cycle read return.
// Define SPRAM_ARB_CLEAR_EN to zero the whole RAM after reset before serving requests.
module spram_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    spram_arbiter_if.slave   bus,
    output logic             busy,
    output logic             ram_we,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_data,
    input  logic [WIDTH-1:0] ram_out
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state, state_d;
    logic             gnt_a_d, gnt_b_d;
    logic             ram_we_d;
    logic [DEPTH-1:0] ram_addr_d;
    logic [WIDTH-1:0] ram_data_d;
    logic             prio_b, prio_b_d;
    logic             elig_a, elig_b;
    logic             pend_a, pend_b;

`ifdef SPRAM_ARB_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    logic [DEPTH-1:0] clr_cnt, clr_cnt_d;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= RESET_STATE;
        else          state <= state_d;
    end

    // Next state, arbitration and RAM command selection
    always_comb begin
        state_d    = state;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr;
        ram_data_d = ram_data;
        prio_b_d   = prio_b;
`ifdef SPRAM_ARB_CLEAR_EN
        clr_cnt_d  = clr_cnt;
`endif
        // A requester that was just granted is still holding req for one cycle
        elig_a = bus.req_a & ~bus.gnt_a;
        elig_b = bus.req_b & ~bus.gnt_b;

        case (state)
            CLEAR: begin
`ifdef SPRAM_ARB_CLEAR_EN
                ram_we_d   = 1'b1;
                ram_addr_d = clr_cnt;
                ram_data_d = '0;
                clr_cnt_d  = clr_cnt + DEPTH'(1);
                if (clr_cnt == {DEPTH{1'b1}}) state_d = RUN;
`else
                state_d = RUN;
`endif
            end
            RUN: begin
                if (elig_a && (!elig_b || !prio_b)) begin
                    gnt_a_d    = 1'b1;
                    ram_we_d   = bus.we_a;
                    ram_addr_d = bus.addr_a;
                    ram_data_d = bus.wdata_a;
                    prio_b_d   = 1'b1;
                end else if (elig_b) begin
                    gnt_b_d    = 1'b1;
                    ram_we_d   = bus.we_b;
                    ram_addr_d = bus.addr_b;
                    ram_data_d = bus.wdata_b;
                    prio_b_d   = 1'b0;
                end
            end
        endcase
    end

    // Registered grants, RAM controls and read-return pipeline
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.gnt_a    <= 1'b0;
            bus.gnt_b    <= 1'b0;
            bus.rvalid_a <= 1'b0;
            bus.rvalid_b <= 1'b0;
            bus.rdata_a  <= '0;
            bus.rdata_b  <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
            prio_b       <= 1'b0;
            pend_a       <= 1'b0;
            pend_b       <= 1'b0;
        end else begin
            bus.gnt_a    <= gnt_a_d;
            bus.gnt_b    <= gnt_b_d;
            ram_we       <= ram_we_d;
            ram_addr     <= ram_addr_d;
            ram_data     <= ram_data_d;
            prio_b       <= prio_b_d;
            // RAM samples the address one cycle after grant; data is captured one cycle later
            pend_a       <= bus.gnt_a & ~ram_we;
            pend_b       <= bus.gnt_b & ~ram_we;
            bus.rvalid_a <= pend_a;
            bus.rvalid_b <= pend_b;
            if (pend_a) bus.rdata_a <= ram_out;
            if (pend_b) bus.rdata_b <= ram_out;
        end
    end

`ifdef SPRAM_ARB_CLEAR_EN
    // Sweep counter and busy flag aligned with the clear writes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            clr_cnt <= clr_cnt_d;
            busy    <= (state == CLEAR);
        end
    end
`else
    assign busy = 1'b0;
`endif
endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_spram_arbiter;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WORDS = 16;
`ifdef SPRAM_ARB_CLEAR_EN
    localparam int CLEAR_CYCLES = 16;
`else
    localparam int CLEAR_CYCLES = 0;
`endif

    logic             clock;
    logic             reset_n;
    logic             busy;
    logic             ram_we;
    logic [DEPTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_data;
    logic [WIDTH-1:0] ram_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    spram_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    spram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy     (busy),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_out  (ram_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM: write and registered read one cycle after address
    logic [WIDTH-1:0] ram_mem [WORDS];
    initial begin
        foreach (ram_mem[i]) ram_mem[i] = '0;
        ram_out = '0;
    end
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_out <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int         due;
        bit         who_b;
        logic [7:0] data;
    } rd_t;

    rd_t        rd_q[$];
    int         cyc = 0;
    int         m_clear_left = 0;
    bit         m_last_a = 0;
    logic       m_gnt_a = 0, m_gnt_b = 0, m_rv_a = 0, m_rv_b = 0;
    logic [7:0] m_rd_a = 0, m_rd_b = 0, m_data = 0;
    logic [3:0] m_addr = 0;
    logic       m_we = 0, m_busy = 0;
    logic [7:0] ref_mem [WORDS];
    initial foreach (ref_mem[i]) ref_mem[i] = '0;

    always begin
        bit ea, eb, pick_b;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            m_gnt_a = 0; m_gnt_b = 0; m_rv_a = 0; m_rv_b = 0;
            m_rd_a = 0; m_rd_b = 0; m_we = 0; m_addr = 0; m_data = 0;
            m_busy = 0; m_last_a = 0;
            rd_q.delete();
            m_clear_left = CLEAR_CYCLES;
        end else begin
            m_rv_a = 0; m_rv_b = 0;
            while (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                if (rd_q[0].who_b) begin m_rv_b = 1; m_rd_b = rd_q[0].data; end
                else               begin m_rv_a = 1; m_rd_a = rd_q[0].data; end
                void'(rd_q.pop_front());
            end
            ea = bus.req_a && !m_gnt_a;
            eb = bus.req_b && !m_gnt_b;
            m_gnt_a = 0; m_gnt_b = 0; m_we = 0;
            if (m_clear_left > 0) begin
                m_busy = 1; m_we = 1;
                m_addr = 4'(WORDS - m_clear_left);
                m_data = 0;
                ref_mem[m_addr] = 0;
                m_clear_left--;
            end else begin
                m_busy = 0;
                pick_b = (ea && eb) ? m_last_a : eb;
                if (ea || eb) begin
                    m_last_a = !pick_b;
                    if (pick_b) begin
                        m_gnt_b = 1; m_we = bus.we_b; m_addr = bus.addr_b; m_data = bus.wdata_b;
                    end else begin
                        m_gnt_a = 1; m_we = bus.we_a; m_addr = bus.addr_a; m_data = bus.wdata_a;
                    end
                    if (m_we) ref_mem[m_addr] = m_data;
                    else      rd_q.push_back('{cyc + 2, pick_b, ref_mem[m_addr]});
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model
    always begin
        @(negedge clock);
        if (chk_en) begin
            check("m_gnt_a",    32'(bus.gnt_a),    32'(m_gnt_a));
            check("m_gnt_b",    32'(bus.gnt_b),    32'(m_gnt_b));
            check("m_rvalid_a", 32'(bus.rvalid_a), 32'(m_rv_a));
            check("m_rvalid_b", 32'(bus.rvalid_b), 32'(m_rv_b));
            check("m_rdata_a",  32'(bus.rdata_a),  32'(m_rd_a));
            check("m_rdata_b",  32'(bus.rdata_b),  32'(m_rd_b));
            check("m_ram_we",   32'(ram_we),       32'(m_we));
            check("m_ram_addr", 32'(ram_addr),     32'(m_addr));
            check("m_ram_data", 32'(ram_data),     32'(m_data));
            check("m_busy",     32'(busy),         32'(m_busy));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       req_a, we_a;
        logic [3:0] addr_a;
        logic [7:0] wdata_a;
        logic       req_b, we_b;
        logic [3:0] addr_b;
        logic [7:0] wdata_b;
        logic       gnt_a, gnt_b, rv_a;
        logic [7:0] rd_a;
        logic       rv_b;
        logic [7:0] rd_b;
    } vec_t;

    function automatic vec_t mk(bit ra, bit wa, int aa, int da, bit rb, bit wb, int ab, int db,
                                bit ga, bit gb, bit va, int xa, bit vb, int xb);
        vec_t v;
        v.req_a = ra; v.we_a = wa; v.addr_a = 4'(aa); v.wdata_a = 8'(da);
        v.req_b = rb; v.we_b = wb; v.addr_b = 4'(ab); v.wdata_b = 8'(db);
        v.gnt_a = ga; v.gnt_b = gb; v.rv_a = va; v.rd_a = 8'(xa); v.rv_b = vb; v.rd_b = 8'(xb);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.req_a = v.req_a; bus.we_a = v.we_a; bus.addr_a = v.addr_a; bus.wdata_a = v.wdata_a;
        bus.req_b = v.req_b; bus.we_b = v.we_b; bus.addr_b = v.addr_b; bus.wdata_b = v.wdata_b;
    endtask

    task automatic wait_clear();
        for (int i = 0; i < 40 && m_clear_left > 0; i++) @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        wait_clear();
    endtask

    vec_t tbl[12];
    vec_t idle;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
        tbl[0]  = mk(1,1, 3,'hA5, 0,0, 0,0,    1,0, 0,'h00, 0,'h00);
        tbl[1]  = mk(1,0, 3,0,    0,0, 0,0,    0,0, 0,'h00, 0,'h00);
        tbl[2]  = mk(1,0, 3,0,    0,0, 0,0,    1,0, 0,'h00, 0,'h00);
        tbl[3]  = mk(0,0, 0,0,    0,0, 0,0,    0,0, 0,'h00, 0,'h00);
        tbl[4]  = mk(0,0, 0,0,    0,0, 0,0,    0,0, 1,'hA5, 0,'h00);
        tbl[5]  = mk(0,0, 0,0,    0,0, 0,0,    0,0, 0,'hA5, 0,'h00);
        tbl[6]  = mk(0,0, 0,0,    1,1,15,'hFF, 0,1, 0,'hA5, 0,'h00);
        tbl[7]  = mk(1,0,15,0,    1,0, 0,0,    1,0, 0,'hA5, 0,'h00);
        tbl[8]  = mk(0,0, 0,0,    1,0, 0,0,    0,1, 0,'hA5, 0,'h00);
        tbl[9]  = mk(0,0, 0,0,    0,0, 0,0,    0,0, 1,'hFF, 0,'h00);
        tbl[10] = mk(0,0, 0,0,    0,0, 0,0,    0,0, 0,'hFF, 1,'h00);
        tbl[11] = mk(0,0, 0,0,    0,0, 0,0,    0,0, 0,'hFF, 0,'h00);

        reset_n = 1'b0;
        drive(idle);
        repeat (2) @(negedge clock);
        chk_en = 1;
        reset_n = 1'b1;
        wait_clear();

        // Write/read-back, round-robin under contention, unwritten read
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            @(negedge clock);
            check($sformatf("vec%0d_gnt_a", i),    32'(bus.gnt_a),    32'(tbl[i].gnt_a));
            check($sformatf("vec%0d_gnt_b", i),    32'(bus.gnt_b),    32'(tbl[i].gnt_b));
            check($sformatf("vec%0d_rvalid_a", i), 32'(bus.rvalid_a), 32'(tbl[i].rv_a));
            check($sformatf("vec%0d_rdata_a", i),  32'(bus.rdata_a),  32'(tbl[i].rd_a));
            check($sformatf("vec%0d_rvalid_b", i), 32'(bus.rvalid_b), 32'(tbl[i].rv_b));
            check($sformatf("vec%0d_rdata_b", i),  32'(bus.rdata_b),  32'(tbl[i].rd_b));
        end

        // Both requesters held: A,B,A,B... starting with A after reset
        do_reset();
        drive(mk(1,0,15,0, 1,0,3,0, 0,0,0,0,0,0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("alt%0d_gnt_a", i), 32'(bus.gnt_a), 32'(i % 2 == 0));
            check($sformatf("alt%0d_gnt_b", i), 32'(bus.gnt_b), 32'(i % 2 == 1));
            check($sformatf("alt%0d_both", i),  32'(bus.gnt_a & bus.gnt_b), 32'd0);
        end
        drive(idle);
        repeat (3) @(negedge clock);

        // Single requester: at most one grant every other cycle
        drive(mk(0,0,0,0, 1,0,3,0, 0,0,0,0,0,0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("solo%0d_gnt_b", i), 32'(bus.gnt_b), 32'(i % 2 == 0));
        end
        drive(idle);
        repeat (3) @(negedge clock);

        // Reset right after a read grant discards the read
        drive(mk(1,0,15,0, 0,0,0,0, 0,0,0,0,0,0));
        @(negedge clock);
        check("rst_pre_gnt_a", 32'(bus.gnt_a), 32'd1);
        drive(idle);
        reset_n = 1'b0;
        @(negedge clock);
        check("rst_gnt_a",    32'(bus.gnt_a),    32'd0);
        check("rst_gnt_b",    32'(bus.gnt_b),    32'd0);
        check("rst_rvalid_a", 32'(bus.rvalid_a), 32'd0);
        check("rst_rvalid_b", 32'(bus.rvalid_b), 32'd0);
        check("rst_rdata_a",  32'(bus.rdata_a),  32'd0);
        check("rst_rdata_b",  32'(bus.rdata_b),  32'd0);
        check("rst_ram_we",   32'(ram_we),       32'd0);
        check("rst_ram_addr", 32'(ram_addr),     32'd0);
        check("rst_ram_data", 32'(ram_data),     32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("rst_post%0d_rvalid_a", i), 32'(bus.rvalid_a), 32'd0);
        end
        wait_clear();

`ifdef SPRAM_ARB_CLEAR_EN
        // Clear sweep with a request held throughout
        drive(mk(1,0,15,0, 0,0,0,0, 0,0,0,0,0,0));
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check($sformatf("clr%0d_busy", k),     32'(busy),      32'd1);
            check($sformatf("clr%0d_ram_we", k),   32'(ram_we),    32'd1);
            check($sformatf("clr%0d_ram_addr", k), 32'(ram_addr),  32'(k));
            check($sformatf("clr%0d_ram_data", k), 32'(ram_data),  32'd0);
            check($sformatf("clr%0d_gnt_a", k),    32'(bus.gnt_a), 32'd0);
        end
        @(negedge clock);
        check("clr_done_busy",  32'(busy),      32'd0);
        check("clr_done_gnt_a", 32'(bus.gnt_a), 32'd1);
        drive(idle);
        repeat (3) @(negedge clock);
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if (!bus.req_a || bus.gnt_a) begin
                bus.req_a   = ($urandom_range(0, 3) != 0);
                bus.we_a    = $urandom_range(0, 1) == 1;
                bus.addr_a  = 4'($urandom_range(0, 15));
                bus.wdata_a = 8'($urandom);
            end
            if (!bus.req_b || bus.gnt_b) begin
                bus.req_b   = ($urandom_range(0, 3) != 0);
                bus.we_b    = $urandom_range(0, 1) == 1;
                bus.addr_b  = 4'($urandom_range(0, 15));
                bus.wdata_b = 8'($urandom);
            end
            reset_n = ($urandom_range(0, 79) != 0);
            @(negedge clock);
        end
        drive(idle);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
